// File: rtl/umul8_arb2_pkg.sv
// Shared definitions for the two-requester shared 8x8 unsigned multiplier.
package umul8_arb2_pkg;

    localparam int OPER_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, pointer advances on every accepted grant.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic val0,
    input  logic val1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    logic ptr;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        gnt_id = ptr;
        if (val0 && !val1) begin
            gnt_id = 1'b0;
        end else if (val1 && !val0) begin
            gnt_id = 1'b1;
        end
        gnt0 = val0 && !gnt_id;
        gnt1 = val1 && gnt_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/umul8_arb2.sv
// One 8x8 unsigned multiplier shared by two val/rdy requesters, one transaction in flight.
module umul8_arb2
    import umul8_arb2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic [OPER_W-1:0] req0_a,
    input  logic [OPER_W-1:0] req0_b,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic [OPER_W-1:0] req1_a,
    input  logic [OPER_W-1:0] req1_b,
    output logic              resp0_val,
    input  logic              resp0_rdy,
    output logic [PROD_W-1:0] resp0_prod,
    output logic              resp1_val,
    input  logic              resp1_rdy,
    output logic [PROD_W-1:0] resp1_prod
);

    state_t            state;
    state_t            state_nxt;
    logic [OPER_W-1:0] a_p0;
    logic [OPER_W-1:0] b_p0;
    logic              id_p0;
    logic [PROD_W-1:0] prod_p1;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_id;
    logic              idle;
    logic              req_xfer;
    logic              resp_xfer;

    assign idle = (state == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .val0    (req0_val),
        .val1    (req1_val),
        .advance (req_xfer),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    // Grants already include val, so any rdy in IDLE is a transfer.
    assign req0_rdy  = idle && gnt0;
    assign req1_rdy  = idle && gnt1;
    assign req_xfer  = req0_rdy || req1_rdy;

    assign resp0_val  = (state == RESP) && !id_p0;
    assign resp1_val  = (state == RESP) && id_p0;
    assign resp_xfer  = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);
    assign resp0_prod = prod_p1;
    assign resp1_prod = prod_p1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_xfer) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (resp_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: operand capture from the winning requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_p0  <= '0;
            b_p0  <= '0;
            id_p0 <= 1'b0;
        end else if (req_xfer) begin
            a_p0  <= gnt_id ? req1_a : req0_a;
            b_p0  <= gnt_id ? req1_b : req0_b;
            id_p0 <= gnt_id;
        end
    end

    // Stage p1: full-width product, held until the response is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_p1 <= '0;
        end else if (state == CALC) begin
            prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
        end
    end

endmodule

// File: doc/umul8_arb2.md
UMUL8_ARB2 -- requirements
Module: umul8_arb2

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (operands 8 bits, product 16 bits).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_val  input  1  requester 0 has a valid operand pair.
REQ-005 req0_rdy  output  1  block accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 unsigned operands.
REQ-007 req1_val, req1_rdy, req1_a, req1_b  same as REQ-004..006, requester 1.
REQ-008 resp0_val  output  1  product for requester 0 is valid.
REQ-009 resp0_rdy  input  1  requester 0 consumes the product.
REQ-010 resp0_prod  output  16  unsigned product for requester 0.
REQ-011 resp1_val, resp1_rdy, resp1_prod  same as REQ-008..010, requester 1.

Function
REQ-012 The block SHALL share one 8x8 unsigned multiplier between two requesters, with one transaction outstanding at a time.
REQ-013 The FSM SHALL have states IDLE, CALC, RESP; reset state IDLE.
REQ-014 A transfer on any val/rdy port SHALL occur only in a cycle where both val and rdy are high.
REQ-015 In IDLE, reqN_rdy SHALL be high only for the granted requester; both rdy low in CALC and RESP.
REQ-016 Grant: if exactly one reqN_val is high, grant it; if both, grant the requester named by the priority pointer.
REQ-017 The grant SHALL be a combinational function of req*_val and the pointer; rdy SHALL NOT depend on resp*_rdy.
REQ-018 On a request transfer: latch a, b and the winner ID (1 bit); pointer becomes the loser's index (other than the winner); IDLE->CALC.
REQ-019 The pointer SHALL update only on a request transfer, including when only one requester was valid.
REQ-020 CALC: register the product {a*b, 16-bit zero-extended, no truncation}; always CALC->RESP after one cycle.
REQ-021 RESP: assert respN_val only for the latched ID; respN_prod holds the registered product; the other resp_val stays low.
REQ-022 RESP->IDLE on the response transfer; otherwise hold RESP with val and prod stable (backpressure has no limit).
REQ-023 Latency: response valid two cycles after the request-transfer edge; minimum issue interval 3 cycles.
REQ-024 Both respN_prod outputs SHALL carry the product register (0 after reset); only val qualifies them.
REQ-025 Boundary: 255*255 SHALL give 16'hFE01; 0*x gives 0.
REQ-026 A new request arriving in CALC/RESP SHALL be held off (rdy low), never dropped or overwritten.

Reset
REQ-027 Reset SHALL force state IDLE, pointer = 0, operand, ID and product registers = 0.
REQ-028 Reset SHALL take priority over every other event, including a transfer in the same cycle.
REQ-029 Reset mid-transaction SHALL abandon the transaction: resp*_val low the cycle after reset; no product is delivered.
REQ-030 During reset and the first cycle after, all req_rdy and resp_val SHALL follow IDLE/pointer-0 rules.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, CALC, RESP) and the operand/product width constants (8, 16).
REQ-032 The two-input round-robin arbiter (grant logic + pointer) SHALL be a separate sub-module, rr_arb2.
REQ-033 The multiply SHALL be a single combinational operator feeding the product register; no other arithmetic.

Verification
REQ-034 Single: req0 a=3 b=5 -> resp0_val two cycles later, prod=15; resp1_val never high.
REQ-035 Contention after reset: both val, req0 3*4, req1 7*9 -> req0 first (prod 12), then req1 (prod 63).
REQ-036 Fairness: both val continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-037 Backpressure: resp1_rdy low 5 cycles on 255*255 -> resp1_val held, prod stays 16'hFE01; both req_rdy low throughout.
REQ-038 Reset in CALC with 10*10 pending -> state IDLE, no resp_val, next req1 4*4 gives 16.
REQ-039 Random: 1000 transactions, random val/rdy; each product = a*b routed to the correct requester, in issue order.
